// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
//
// Writeback arbiter. Each writeback group independently selects one of its
// completing units per cycle using a round-robin pointer. It acks the selected
// unit in the same cycle and forwards that unit's id/data as the group's
// writeback packet. The packet is either combinational (REG_OUT=0) or
// registered (REG_OUT=1). A per-group snoop shift pipeline delays the
// writeback packet by SNOOP_DEPTH cycles for store forwarding in the LSU.
//
// Ports
//   clk          clock
//   rst          synchronous active-high reset
//   unit_done    [NUM_GROUPS*U]         unit has a result ready, bit g*U+u
//   unit_id      [NUM_GROUPS*U*ID_W]    result id per unit, same indexing
//   unit_data    [NUM_GROUPS*U*DATA_W]  result data per unit
//   unit_ack     [NUM_GROUPS*U]         one-hot per group, unit accepted this cycle
//   wb_valid     [NUM_GROUPS]           writeback packet valid per group
//   wb_id        [NUM_GROUPS*ID_W]      packet id (don't-care when not valid)
//   wb_data      [NUM_GROUPS*DATA_W]    packet data (don't-care when not valid)
//   snoop_valid  [NUM_GROUPS]           wb_valid delayed SNOOP_DEPTH cycles
//   snoop_id     [NUM_GROUPS*ID_W]      wb_id delayed SNOOP_DEPTH cycles
//   snoop_data   [NUM_GROUPS*DATA_W]    wb_data delayed SNOOP_DEPTH cycles
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
    parameter int NUM_GROUPS      = 3,
    parameter int UNITS_PER_GROUP = 4,
    parameter int ID_W            = 3,
    parameter int DATA_W          = 32,
    parameter int REG_OUT         = 0,
    parameter int SNOOP_DEPTH     = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [NUM_GROUPS*UNITS_PER_GROUP-1:0]        unit_done,
    input  logic [NUM_GROUPS*UNITS_PER_GROUP*ID_W-1:0]   unit_id,
    input  logic [NUM_GROUPS*UNITS_PER_GROUP*DATA_W-1:0] unit_data,
    output logic [NUM_GROUPS*UNITS_PER_GROUP-1:0]        unit_ack,
    output logic [NUM_GROUPS-1:0]                        wb_valid,
    output logic [NUM_GROUPS*ID_W-1:0]                   wb_id,
    output logic [NUM_GROUPS*DATA_W-1:0]                 wb_data,
    output logic [NUM_GROUPS-1:0]                        snoop_valid,
    output logic [NUM_GROUPS*ID_W-1:0]                   snoop_id,
    output logic [NUM_GROUPS*DATA_W-1:0]                 snoop_data
);

    localparam int U     = UNITS_PER_GROUP;
    localparam int PTR_W = (U > 1) ? $clog2(U) : 1;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_GROUPS; gi++) begin : g_grp
            logic [U-1:0]        done_g;
            logic [PTR_W-1:0]    rr_ptr_reg;
            logic [PTR_W-1:0]    rr_ptr_next;
            logic [PTR_W-1:0]    grant_idx;
            logic                grant_any;
            logic [U-1:0]        grant;
            logic [ID_W-1:0]     sel_id;
            logic [DATA_W-1:0]   sel_data;
            logic                wb_valid_g;
            logic [ID_W-1:0]     wb_id_g;
            logic [DATA_W-1:0]   wb_data_g;
            logic [SNOOP_DEPTH-1:0] sn_valid_reg;
            logic [ID_W-1:0]     sn_id_reg   [SNOOP_DEPTH];
            logic [DATA_W-1:0]   sn_data_reg [SNOOP_DEPTH];

            assign done_g = unit_done[gi*U +: U];

            // Round-robin pick. Scanning from the top down and overwriting
            // leaves idx_lo at the lowest requester overall and idx_hi at the
            // lowest requester at or above the pointer. When nothing is at or
            // above the pointer, the lowest overall is necessarily below it,
            // which is the wrap-around choice.
            always_comb begin : grant_sel
                logic             found_hi;
                logic [PTR_W-1:0] idx_hi;
                logic [PTR_W-1:0] idx_lo;
                found_hi = 1'b0;
                idx_hi   = '0;
                idx_lo   = '0;
                for (int u = U - 1; u >= 0; u--) begin
                    if (done_g[u]) begin
                        idx_lo = PTR_W'(u);
                        if (u >= int'(rr_ptr_reg)) begin
                            idx_hi   = PTR_W'(u);
                            found_hi = 1'b1;
                        end
                    end
                end
                grant_idx = found_hi ? idx_hi : idx_lo;
                // No grants while in reset. Units keep their results and
                // re-present them once reset is released.
                grant_any = (|done_g) && !rst;
                grant     = '0;
                if (grant_any) begin
                    grant[grant_idx] = 1'b1;
                end
            end

            // The pointer moves past the winner. The wrap is explicit so that
            // non-power-of-two unit counts never reach the value U.
            always_comb begin
                rr_ptr_next = rr_ptr_reg;
                if (grant_any) begin
                    if (int'(grant_idx) == U - 1) begin
                        rr_ptr_next = '0;
                    end else begin
                        rr_ptr_next = grant_idx + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rr_ptr_reg <= '0;
                end else begin
                    rr_ptr_reg <= rr_ptr_next;
                end
            end

            assign unit_ack[gi*U +: U] = grant;

            // Payload mux driven by the one-hot grant.
            always_comb begin
                sel_id   = '0;
                sel_data = '0;
                for (int u = 0; u < U; u++) begin
                    if (grant[u]) begin
                        sel_id   = unit_id[(gi*U + u)*ID_W +: ID_W];
                        sel_data = unit_data[(gi*U + u)*DATA_W +: DATA_W];
                    end
                end
            end

            if (REG_OUT != 0) begin : g_reg_out
                logic              wb_valid_reg;
                logic [ID_W-1:0]   wb_id_reg;
                logic [DATA_W-1:0] wb_data_reg;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        wb_valid_reg <= 1'b0;
                    end else begin
                        wb_valid_reg <= grant_any;
                    end
                end

                // Payload is qualified by wb_valid, so it needs no reset.
                always_ff @(posedge clk) begin
                    wb_id_reg   <= sel_id;
                    wb_data_reg <= sel_data;
                end

                assign wb_valid_g = wb_valid_reg;
                assign wb_id_g    = wb_id_reg;
                assign wb_data_g  = wb_data_reg;
            end else begin : g_comb_out
                assign wb_valid_g = grant_any;
                assign wb_id_g    = sel_id;
                assign wb_data_g  = sel_data;
            end

            // Snoop pipeline: stage 0 samples the writeback packet every cycle.
            // The last stage is the snoop output.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sn_valid_reg <= '0;
                end else begin
                    sn_valid_reg[0] <= wb_valid_g;
                    for (int s = 1; s < SNOOP_DEPTH; s++) begin
                        sn_valid_reg[s] <= sn_valid_reg[s-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                sn_id_reg[0]   <= wb_id_g;
                sn_data_reg[0] <= wb_data_g;
                for (int s = 1; s < SNOOP_DEPTH; s++) begin
                    sn_id_reg[s]   <= sn_id_reg[s-1];
                    sn_data_reg[s] <= sn_data_reg[s-1];
                end
            end

            assign wb_valid[gi]                    = wb_valid_g;
            assign wb_id[gi*ID_W +: ID_W]          = wb_id_g;
            assign wb_data[gi*DATA_W +: DATA_W]    = wb_data_g;
            assign snoop_valid[gi]                 = sn_valid_reg[SNOOP_DEPTH-1];
            assign snoop_id[gi*ID_W +: ID_W]       = sn_id_reg[SNOOP_DEPTH-1];
            assign snoop_data[gi*DATA_W +: DATA_W] = sn_data_reg[SNOOP_DEPTH-1];
        end
    endgenerate

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_rr_arbiter
//
// Scoreboard bench for wb_rr_arbiter.
//   dut_a: 3 groups x 4 units, registered outputs, snoop depth 2.
//   dut_b: 1 group  x 3 units, combinational outputs, snoop depth 1.
// The stimulus processes apply hand-computed vectors. For each expected
// grant, they push the expected ack, writeback and snoop entries, each tagged
// with the cycle in which it must appear. A monitor on the falling edge pops
// an entry and compares it whenever the DUT shows an ack or a valid.
// -----------------------------------------------------------------------------
module tb_wb_rr_arbiter;

    typedef struct {
        int          cyc;
        int          unit;
        logic [2:0]  id;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit mon_en = 1'b0;

    // ---------------- DUT A ----------------
    logic        rst_a;
    logic [11:0] unit_done_a;
    logic [35:0] unit_id_a;
    logic [383:0] unit_data_a;
    logic [11:0] unit_ack_a;
    logic [2:0]  wb_valid_a;
    logic [8:0]  wb_id_a;
    logic [95:0] wb_data_a;
    logic [2:0]  snoop_valid_a;
    logic [8:0]  snoop_id_a;
    logic [95:0] snoop_data_a;

    wb_rr_arbiter #(
        .NUM_GROUPS(3), .UNITS_PER_GROUP(4), .ID_W(3), .DATA_W(32),
        .REG_OUT(1), .SNOOP_DEPTH(2)
    ) dut_a (
        .clk(clk), .rst(rst_a),
        .unit_done(unit_done_a), .unit_id(unit_id_a), .unit_data(unit_data_a),
        .unit_ack(unit_ack_a),
        .wb_valid(wb_valid_a), .wb_id(wb_id_a), .wb_data(wb_data_a),
        .snoop_valid(snoop_valid_a), .snoop_id(snoop_id_a), .snoop_data(snoop_data_a)
    );

    // ---------------- DUT B ----------------
    logic        rst_b;
    logic [2:0]  unit_done_b;
    logic [8:0]  unit_id_b;
    logic [95:0] unit_data_b;
    logic [2:0]  unit_ack_b;
    logic [0:0]  wb_valid_b;
    logic [2:0]  wb_id_b;
    logic [31:0] wb_data_b;
    logic [0:0]  snoop_valid_b;
    logic [2:0]  snoop_id_b;
    logic [31:0] snoop_data_b;

    wb_rr_arbiter #(
        .NUM_GROUPS(1), .UNITS_PER_GROUP(3), .ID_W(3), .DATA_W(32),
        .REG_OUT(0), .SNOOP_DEPTH(1)
    ) dut_b (
        .clk(clk), .rst(rst_b),
        .unit_done(unit_done_b), .unit_id(unit_id_b), .unit_data(unit_data_b),
        .unit_ack(unit_ack_b),
        .wb_valid(wb_valid_b), .wb_id(wb_id_b), .wb_data(wb_data_b),
        .snoop_valid(snoop_valid_b), .snoop_id(snoop_id_b), .snoop_data(snoop_data_b)
    );

    // Expected queues
    exp_t a_ack_q [3][$];
    exp_t a_wb_q  [3][$];
    exp_t a_sn_q  [3][$];
    exp_t b_ack_q [$];
    exp_t b_wb_q  [$];
    exp_t b_sn_q  [$];

    function automatic logic [2:0] a_id(int n, int g, int u);
        return 3'((n + g + u + 1) % 8);
    endfunction
    function automatic logic [31:0] a_data(int n, int g, int u);
        return {8'(n), 8'(g), 8'(u), 8'hC3};
    endfunction
    function automatic logic [2:0] b_id(int n, int u);
        return 3'((n + u + 2) % 8);
    endfunction
    function automatic logic [31:0] b_data(int n, int u);
        return {8'(n), 8'h0B, 8'(u), 8'h3C};
    endfunction

    // One comparison: sz is the queue depth before the pop (0 => nothing expected).
    function automatic void check(string nm, int g, int sz, exp_t e, int unit_act,
                                  logic [2:0] id_act, logic [31:0] d_act, bit is_ack);
        bit ok;
        total++;
        if (sz == 0) begin
            bad++;
            $display("FAIL %s g%0d cycle %0d: got unit=%0d id=%0d data=%h, want nothing",
                     nm, g, cyc, unit_act, id_act, d_act);
            return;
        end
        ok = (e.cyc == cyc);
        if (is_ack) ok = ok && (unit_act == e.unit);
        else        ok = ok && (id_act == e.id) && (d_act == e.data);
        if (!ok) begin
            bad++;
            $display("FAIL %s g%0d cycle %0d: got unit=%0d id=%0d data=%h, want cycle=%0d unit=%0d id=%0d data=%h",
                     nm, g, cyc, unit_act, id_act, d_act, e.cyc, e.unit, e.id, e.data);
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            int   sz;
            int   ua;
            if (rst_a) begin
                total++;
                if (wb_valid_a != 3'b000 || snoop_valid_a != 3'b000) begin
                    bad++;
                    $display("FAIL a_reset cycle %0d: wb_valid=%b snoop_valid=%b, want 000/000",
                             cyc, wb_valid_a, snoop_valid_a);
                end
            end else begin
                for (int g = 0; g < 3; g++) begin
                    if (unit_ack_a[g*4 +: 4] != 4'b0000) begin
                        ua = -1;
                        if ($countones(unit_ack_a[g*4 +: 4]) == 1)
                            for (int u = 0; u < 4; u++) if (unit_ack_a[g*4+u]) ua = u;
                        sz = a_ack_q[g].size();
                        e  = '{default: 0};
                        if (sz > 0) e = a_ack_q[g].pop_front();
                        check("a_ack", g, sz, e, ua, 3'd0, 32'd0, 1'b1);
                    end
                    if (wb_valid_a[g]) begin
                        sz = a_wb_q[g].size();
                        e  = '{default: 0};
                        if (sz > 0) e = a_wb_q[g].pop_front();
                        check("a_wb", g, sz, e, e.unit, wb_id_a[g*3 +: 3], wb_data_a[g*32 +: 32], 1'b0);
                    end
                    if (snoop_valid_a[g]) begin
                        sz = a_sn_q[g].size();
                        e  = '{default: 0};
                        if (sz > 0) e = a_sn_q[g].pop_front();
                        check("a_snoop", g, sz, e, e.unit, snoop_id_a[g*3 +: 3], snoop_data_a[g*32 +: 32], 1'b0);
                    end
                end
            end
            if (unit_ack_b != 3'b000) begin
                ua = -1;
                if ($countones(unit_ack_b) == 1)
                    for (int u = 0; u < 3; u++) if (unit_ack_b[u]) ua = u;
                sz = b_ack_q.size();
                e  = '{default: 0};
                if (sz > 0) e = b_ack_q.pop_front();
                check("b_ack", 0, sz, e, ua, 3'd0, 32'd0, 1'b1);
            end
            if (wb_valid_b[0]) begin
                sz = b_wb_q.size();
                e  = '{default: 0};
                if (sz > 0) e = b_wb_q.pop_front();
                check("b_wb", 0, sz, e, e.unit, wb_id_b, wb_data_b, 1'b0);
            end
            if (snoop_valid_b[0]) begin
                sz = b_sn_q.size();
                e  = '{default: 0};
                if (sz > 0) e = b_sn_q.pop_front();
                check("b_snoop", 0, sz, e, e.unit, snoop_id_b, snoop_data_b, 1'b0);
            end
        end
    end

    // ---------------- stimulus A ----------------
    // Drive one vector for this cycle and push the hand-computed expected winners.
    task automatic drive_a(input int n, input logic [11:0] dm, input int e0, input int e1, input int e2);
        int ex [3];
        ex = '{e0, e1, e2};
        unit_done_a = dm;
        for (int g = 0; g < 3; g++)
            for (int u = 0; u < 4; u++) begin
                unit_id_a[(g*4+u)*3 +: 3]    = a_id(n, g, u);
                unit_data_a[(g*4+u)*32 +: 32] = a_data(n, g, u);
            end
        for (int g = 0; g < 3; g++)
            if (ex[g] >= 0) begin
                a_ack_q[g].push_back('{cyc, ex[g], a_id(n, g, ex[g]), a_data(n, g, ex[g])});
                a_wb_q[g].push_back('{cyc + 1, ex[g], a_id(n, g, ex[g]), a_data(n, g, ex[g])});
                a_sn_q[g].push_back('{cyc + 3, ex[g], a_id(n, g, ex[g]), a_data(n, g, ex[g])});
            end
        $display("A vec %0d cycle %0d: done=%h expect g0=%0d g1=%0d g2=%0d", n, cyc, dm, e0, e1, e2);
    endtask

    task automatic run_a();
        logic [11:0] tab_done [18];
        int          tab_exp  [18][3];
        tab_done = '{12'h00F, 12'h00F, 12'h00F, 12'h00F, 12'h00F, 12'h00F, 12'h00F, 12'h00F,
                     12'h004, 12'h003, 12'h003, 12'h000, 12'h003,
                     12'h902, 12'h9F0, 12'h6F8, 12'h615, 12'h000};
        tab_exp  = '{'{0,-1,-1}, '{1,-1,-1}, '{2,-1,-1}, '{3,-1,-1},
                     '{0,-1,-1}, '{1,-1,-1}, '{2,-1,-1}, '{3,-1,-1},
                     '{2,-1,-1}, '{0,-1,-1}, '{1,-1,-1}, '{-1,-1,-1}, '{0,-1,-1},
                     '{1,-1,0}, '{-1,0,3}, '{3,1,1}, '{0,0,2}, '{-1,-1,-1}};
        // Reset held two cycles with every unit requesting.
        repeat (2) @(posedge clk);
        for (int n = 0; n < 18; n++) begin
            @(posedge clk); #1;
            rst_a = 1'b0;
            drive_a(n, tab_done[n], tab_exp[n][0], tab_exp[n][1], tab_exp[n][2]);
        end
        // Single isolated grant: g1 unit 2 (pointer 1) with id 5 / 0xDEADBEEF.
        @(posedge clk); #1;
        drive_a(99, 12'h040, -1, -1, -1);
        unit_id_a[(1*4+2)*3 +: 3]     = 3'd5;
        unit_data_a[(1*4+2)*32 +: 32] = 32'hDEADBEEF;
        a_ack_q[1].push_back('{cyc, 2, 3'd5, 32'hDEADBEEF});
        a_wb_q[1].push_back('{cyc + 1, 2, 3'd5, 32'hDEADBEEF});
        a_sn_q[1].push_back('{cyc + 3, 2, 3'd5, 32'hDEADBEEF});
        $display("A latency cycle %0d: g1 u2 id=5 data=deadbeef", cyc);
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            drive_a(100 + n, 12'h000, -1, -1, -1);
        end
    endtask

    // ---------------- stimulus B ----------------
    task automatic run_b();
        bit         tab_rst  [15];
        logic [2:0] tab_done [15];
        int         tab_exp  [15];
        tab_rst  = '{0,0,0,0,0,0,0,0,1,0,0,0,0,0,0};
        tab_done = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                     3'b000, 3'b111, 3'b110, 3'b100, 3'b101, 3'b101, 3'b000};
        tab_exp  = '{0, 1, 2, 0, 1, 2, 0, 1, -1, 0, 1, 2, 0, 2, -1};
        repeat (2) @(posedge clk);
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            rst_b       = tab_rst[n];
            unit_done_b = tab_done[n];
            for (int u = 0; u < 3; u++) begin
                unit_id_b[u*3 +: 3]    = b_id(n, u);
                unit_data_b[u*32 +: 32] = b_data(n, u);
            end
            if (tab_exp[n] >= 0) begin
                b_ack_q.push_back('{cyc, tab_exp[n], b_id(n, tab_exp[n]), b_data(n, tab_exp[n])});
                b_wb_q.push_back('{cyc, tab_exp[n], b_id(n, tab_exp[n]), b_data(n, tab_exp[n])});
                b_sn_q.push_back('{cyc + 1, tab_exp[n], b_id(n, tab_exp[n]), b_data(n, tab_exp[n])});
            end
            $display("B vec %0d cycle %0d: rst=%0d done=%b expect=%0d", n, cyc, tab_rst[n], tab_done[n], tab_exp[n]);
        end
    endtask

    task automatic leftover(string nm, int g, int sz);
        total++;
        if (sz != 0) begin
            bad++;
            $display("FAIL %s g%0d: %0d expected outputs never appeared, want 0", nm, g, sz);
        end
    endtask

    initial begin
        rst_a       = 1'b1;
        unit_done_a = 12'hFFF;
        unit_id_a   = '0;
        unit_data_a = '0;
        rst_b       = 1'b1;
        unit_done_b = 3'b000;
        unit_id_b   = '0;
        unit_data_b = '0;
        fork
            run_a();
            run_b();
            begin
                @(posedge clk); #1;
                mon_en = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            leftover("a_ack", g, a_ack_q[g].size());
            leftover("a_wb", g, a_wb_q[g].size());
            leftover("a_snoop", g, a_sn_q[g].size());
        end
        leftover("b_ack", 0, b_ack_q.size());
        leftover("b_wb", 0, b_wb_q.size());
        leftover("b_snoop", 0, b_sn_q.size());
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
